// File: rtl/reg_sel_pkg.sv
// Shared definitions for the register select sequencer: sequencer state
// encoding and default geometry of the instruction register fields.
package reg_sel_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RB_OUT = 3'd1,
        RC_OUT = 3'd2,
        RA_IN  = 3'd3,
        DONE   = 3'd4
    } seq_state_e;

    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_FIELD_W  = 4;
    localparam int DEF_IR_W     = 32;
    localparam int DEF_RA_LSB   = 23;
    localparam int DEF_RB_LSB   = 19;
    localparam int DEF_RC_LSB   = 15;
    localparam int DEF_IMM_W    = 18;
    localparam int DEF_DATA_W   = 32;

endpackage

// File: rtl/onehot_field_decoder.sv
// Register field to one-hot enable decoder. The enable only gates the
// one-hot vector; the range flag reflects the field value alone so the
// caller decides when an out-of-range field counts as an error.
module onehot_field_decoder
    import reg_sel_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int FIELD_W  = DEF_FIELD_W
) (
    input  logic [FIELD_W-1:0]  field_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o,
    output logic                out_of_range_o
);

    // Match the field against every implemented register index.
    always_comb begin
        onehot_o       = {NUM_REGS{1'b0}};
        out_of_range_o = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (field_i == FIELD_W'(i)) begin
                onehot_o[i]    = en_i;
                out_of_range_o = 1'b0;
            end else begin
                onehot_o[i]    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_select_sequencer.sv
// Register select / encode block with a three-phase operand sequencer.
// Latches the IR, decodes Ra/Rb/Rc into one-hot register-file enables,
// driven either by manual control strobes (IDLE only) or by the
// RB_OUT -> RC_OUT -> RA_IN -> DONE sequence, and produces the
// sign-extended C immediate.
// Optional build macro: SEL_R0_WRITE_PROTECT_EN (R0 never written; any
// write attempt to R0 raises sel_err).
module reg_select_sequencer
    import reg_sel_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int FIELD_W  = DEF_FIELD_W,
    parameter int IR_W     = DEF_IR_W,
    parameter int RA_LSB   = DEF_RA_LSB,
    parameter int RB_LSB   = DEF_RB_LSB,
    parameter int RC_LSB   = DEF_RC_LSB,
    parameter int IMM_W    = DEF_IMM_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                ir_load,
    input  logic [IR_W-1:0]     ir_in,
    input  logic                gra,
    input  logic                grb,
    input  logic                grc,
    input  logic                rin,
    input  logic                rout,
    input  logic                ba_out,
    input  logic                seq_start,
    input  logic                bus_ready,
    output logic                seq_busy,
    output logic                seq_done,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [NUM_REGS-1:0] reg_out,
    output logic                r0_zero_out,
    output logic [DATA_W-1:0]   c_sign_ext,
    output logic                sel_err
);

    localparam logic [FIELD_W-1:0] FIELD_ZERO = {FIELD_W{1'b0}};

    seq_state_e state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;

    logic [NUM_REGS-1:0] reg_in_q, reg_out_q;
    logic r0_zero_q, r0_zero_d;
    logic sel_err_q, sel_err_d;
    logic seq_busy_q, seq_done_q;

    logic [FIELD_W-1:0] ra_s, rb_s, rc_s, sel_field_s;
    logic [FIELD_W-1:0] in_field_s, out_field_s;
    logic in_en_s, out_en_s, in_chk_s, out_chk_s;
    logic [NUM_REGS-1:0] in_onehot_s, out_onehot_s;
    logic in_oor_s, out_oor_s;
    logic manual_s, any_strobe_s, multi_strobe_s;
    logic load_err_s, rule_err_s;
    logic unused_ir_s;

    // Fields are decoded from the IR value that will be live next cycle,
    // so an IR captured together with seq_start is used by that sequence.
    assign ra_s = ir_d[RA_LSB +: FIELD_W];
    assign rb_s = ir_d[RB_LSB +: FIELD_W];
    assign rc_s = ir_d[RC_LSB +: FIELD_W];

    assign manual_s       = (state_q == IDLE) && !seq_start;
    assign any_strobe_s   = gra | grb | grc;
    assign multi_strobe_s = (gra & grb) | (gra & grc) | (grb & grc);
    assign sel_field_s    = grc ? rc_s : (grb ? rb_s : ra_s);
    assign load_err_s     = ir_load && (state_q != IDLE);

    // IR capture is only honoured while the sequencer is idle.
    always_comb begin
        if (ir_load && (state_q == IDLE)) begin
            ir_d = ir_in;
        end else begin
            ir_d = ir_q;
        end
    end

    // Sequencer next-state: each operand phase waits for bus_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (seq_start) begin
                    state_d = RB_OUT;
                end else begin
                    state_d = IDLE;
                end
            end
            RB_OUT: begin
                if (bus_ready) begin
                    state_d = RC_OUT;
                end else begin
                    state_d = RB_OUT;
                end
            end
            RC_OUT: begin
                if (bus_ready) begin
                    state_d = RA_IN;
                end else begin
                    state_d = RC_OUT;
                end
            end
            RA_IN: begin
                if (bus_ready) begin
                    state_d = DONE;
                end else begin
                    state_d = RA_IN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Enable requests for the next cycle, from either the sequencer phase
    // being entered/held or the manual strobes sampled this edge.
    always_comb begin
        in_field_s  = ra_s;
        out_field_s = rb_s;
        in_en_s     = 1'b0;
        out_en_s    = 1'b0;
        in_chk_s    = 1'b0;
        out_chk_s   = 1'b0;
        r0_zero_d   = 1'b0;
        rule_err_s  = 1'b0;
        case (state_d)
            RB_OUT: begin
                out_field_s = rb_s;
                out_en_s    = 1'b1;
                out_chk_s   = (state_q != RB_OUT);
            end
            RC_OUT: begin
                out_field_s = rc_s;
                out_en_s    = 1'b1;
                out_chk_s   = (state_q != RC_OUT);
            end
            RA_IN: begin
                in_field_s = ra_s;
                in_en_s    = 1'b1;
                in_chk_s   = (state_q != RA_IN);
`ifdef SEL_R0_WRITE_PROTECT_EN
                if (ra_s == FIELD_ZERO) begin
                    in_en_s    = 1'b0;
                    rule_err_s = (state_q != RA_IN);
                end else begin
                    in_en_s    = 1'b1;
                end
`endif
            end
            IDLE: begin
                if (manual_s && any_strobe_s) begin
                    in_field_s  = sel_field_s;
                    out_field_s = sel_field_s;
                    in_chk_s    = 1'b1;
                    out_chk_s   = 1'b1;
                    in_en_s     = rin;
                    rule_err_s  = multi_strobe_s;
                    // ba_out on R0 without rout means "drive zero", not R0.
                    if (ba_out && !rout && (sel_field_s == FIELD_ZERO)) begin
                        out_en_s  = 1'b0;
                        r0_zero_d = 1'b1;
                    end else begin
                        out_en_s  = rout | ba_out;
                    end
`ifdef SEL_R0_WRITE_PROTECT_EN
                    if (rin && (sel_field_s == FIELD_ZERO)) begin
                        in_en_s    = 1'b0;
                        rule_err_s = 1'b1;
                    end else begin
                        in_en_s    = rin;
                    end
`endif
                end else begin
                    in_en_s  = 1'b0;
                    out_en_s = 1'b0;
                end
            end
            DONE: begin
                in_en_s  = 1'b0;
                out_en_s = 1'b0;
            end
            default: begin
                in_en_s  = 1'b0;
                out_en_s = 1'b0;
            end
        endcase
    end

    onehot_field_decoder #(
        .NUM_REGS (NUM_REGS),
        .FIELD_W  (FIELD_W)
    ) u_in_dec (
        .field_i        (in_field_s),
        .en_i           (in_en_s),
        .onehot_o       (in_onehot_s),
        .out_of_range_o (in_oor_s)
    );

    onehot_field_decoder #(
        .NUM_REGS (NUM_REGS),
        .FIELD_W  (FIELD_W)
    ) u_out_dec (
        .field_i        (out_field_s),
        .en_i           (out_en_s),
        .onehot_o       (out_onehot_s),
        .out_of_range_o (out_oor_s)
    );

    assign sel_err_d = load_err_s | rule_err_s
                     | (in_chk_s & in_oor_s) | (out_chk_s & out_oor_s);

    // State and instruction register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            ir_q    <= {IR_W{1'b0}};
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Registered enables and status; reset clears them asynchronously.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            reg_in_q   <= {NUM_REGS{1'b0}};
            reg_out_q  <= {NUM_REGS{1'b0}};
            r0_zero_q  <= 1'b0;
            sel_err_q  <= 1'b0;
            seq_busy_q <= 1'b0;
            seq_done_q <= 1'b0;
        end else begin
            reg_in_q   <= in_onehot_s;
            reg_out_q  <= out_onehot_s;
            r0_zero_q  <= r0_zero_d;
            sel_err_q  <= sel_err_d;
            seq_busy_q <= (state_d != IDLE);
            seq_done_q <= (state_d == DONE);
        end
    end

    assign reg_in      = reg_in_q;
    assign reg_out     = reg_out_q;
    assign r0_zero_out = r0_zero_q;
    assign sel_err     = sel_err_q;
    assign seq_busy    = seq_busy_q;
    assign seq_done    = seq_done_q;
    assign c_sign_ext  = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

    // Opcode and other bits outside the decoded fields are not used here.
    assign unused_ir_s = ^ir_q;

endmodule

// File: tb/tb_reg_select_sequencer.sv
// Scoreboard bench for reg_select_sequencer: stimulus pushes hand-computed
// expectations tagged with the cycle they apply to; a monitor compares on
// every falling edge. Honours SEL_R0_WRITE_PROTECT_EN like the design.
module tb_reg_select_sequencer;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        ir_load;
    logic [31:0] ir_in;
    logic        gra, grb, grc, rin, rout, ba_out, seq_start, bus_ready;
    logic        seq_busy, seq_done, r0_zero_out, sel_err;
    logic [15:0] reg_in, reg_out;
    logic [31:0] c_sign_ext;

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] ri;
        logic [15:0] ro;
        logic        r0z;
        logic        err;
        logic        busy;
        logic        done;
        logic [31:0] cx;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    reg_select_sequencer dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .ir_load     (ir_load),
        .ir_in       (ir_in),
        .gra         (gra),
        .grb         (grb),
        .grc         (grc),
        .rin         (rin),
        .rout        (rout),
        .ba_out      (ba_out),
        .seq_start   (seq_start),
        .bus_ready   (bus_ready),
        .seq_busy    (seq_busy),
        .seq_done    (seq_done),
        .reg_in      (reg_in),
        .reg_out     (reg_out),
        .r0_zero_out (r0_zero_out),
        .c_sign_ext  (c_sign_ext),
        .sel_err     (sel_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare the expectation tagged for the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d never checked (now %0d)",
                         exp_q[0].name, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if ({reg_in, reg_out, r0_zero_out, sel_err, seq_busy, seq_done, c_sign_ext} !==
                    {e.ri, e.ro, e.r0z, e.err, e.busy, e.done, e.cx}) begin
                    errors++;
                    $display("FAIL %s: got ri=%h ro=%h r0z=%b err=%b busy=%b done=%b cx=%h, expected ri=%h ro=%h r0z=%b err=%b busy=%b done=%b cx=%h",
                             e.name, reg_in, reg_out, r0_zero_out, sel_err, seq_busy, seq_done, c_sign_ext,
                             e.ri, e.ro, e.r0z, e.err, e.busy, e.done, e.cx);
                end
            end
        end
    end

    task automatic push_exp(input int at, input string nm, input logic [15:0] ri, input logic [15:0] ro,
                            input logic r0z, input logic err, input logic busy, input logic done,
                            input logic [31:0] cx);
        exp_t e;
        e.cyc = at; e.name = nm; e.ri = ri; e.ro = ro; e.r0z = r0z;
        e.err = err; e.busy = busy; e.done = done; e.cx = cx;
        exp_q.push_back(e);
    endtask

    task automatic idle_in();
        ir_load = 1'b0; ir_in = 32'h0000_0000;
        gra = 1'b0; grb = 1'b0; grc = 1'b0;
        rin = 1'b0; rout = 1'b0; ba_out = 1'b0;
        seq_start = 1'b0; bus_ready = 1'b0;
    endtask

    // Inputs are already driven; expect the result of the coming edge.
    task automatic step(input string nm, input logic [15:0] ri, input logic [15:0] ro,
                        input logic r0z, input logic err, input logic busy, input logic done,
                        input logic [31:0] cx);
        push_exp(cyc + 1, nm, ri, ro, r0z, err, busy, done, cx);
        @(negedge clk);
        idle_in();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    localparam logic [31:0] IR_A  = 32'h029B_8000;  // Ra=5 Rb=3 Rc=7
    localparam logic [31:0] CX_A  = 32'hFFFF_8000;
    localparam logic [31:0] IR_B0 = 32'h0283_8000;  // Ra=5 Rb=0 Rc=7

    initial begin
        clr_n = 1'b0;
        idle_in();
        @(negedge clk);
        step("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
        clr_n = 1'b1;

        // 1: manual gra+rin, one cycle only
        ir_load = 1'b1; ir_in = IR_A;
        step("t1_load", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, CX_A);
        gra = 1'b1; rin = 1'b1;
        step("t1_gra_rin", 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, CX_A);
        step("t1_nohold", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, CX_A);

        // 2: full sequence with bus always ready
        seq_start = 1'b1; bus_ready = 1'b1;
        step("t2_rb", 16'h0000, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b0, CX_A);
        bus_ready = 1'b1;
        step("t2_rc", 16'h0000, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b0, CX_A);
        bus_ready = 1'b1;
        step("t2_ra", 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, CX_A);
        bus_ready = 1'b1;
        step("t2_done", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, CX_A);
        step("t2_idle", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, CX_A);

        // 3: stall in RC_OUT; seq_start beats manual strobes without error;
        //    ir_load and strobes while busy are ignored, ir_load flags error
        seq_start = 1'b1; bus_ready = 1'b1; gra = 1'b1; grc = 1'b1; rout = 1'b1;
        step("t3_rb_start_wins", 16'h0000, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b0, CX_A);
        bus_ready = 1'b1;
        step("t3_rc1", 16'h0000, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b0, CX_A);
        step("t3_rc2", 16'h0000, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b0, CX_A);
        ir_load = 1'b1; ir_in = 32'h0002_0000; gra = 1'b1; rin = 1'b1; seq_start = 1'b1;
        step("t3_rc3_busy_load", 16'h0000, 16'h0080, 1'b0, 1'b1, 1'b1, 1'b0, CX_A);
        bus_ready = 1'b1;
        step("t3_ra", 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, CX_A);
        bus_ready = 1'b1;
        step("t3_done", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, CX_A);
        step("t3_idle", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, CX_A);

        // 4: Rb=0 with ba_out drives zero; rout drives R0; rin on R0
        ir_load = 1'b1; ir_in = IR_B0;
        step("t4_load", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, CX_A);
        grb = 1'b1; ba_out = 1'b1;
        step("t4_ba_r0", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, CX_A);
        grb = 1'b1; rout = 1'b1;
        step("t4_rout_r0", 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, CX_A);
        grb = 1'b1; rin = 1'b1;
`ifdef SEL_R0_WRITE_PROTECT_EN
        step("t4_rin_r0", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, CX_A);
`else
        step("t4_rin_r0", 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, CX_A);
`endif

        // 5: immediate sign extension boundaries; sequence with Ra=Rb=0, Rc=3
        ir_load = 1'b1; ir_in = 32'h0002_0000;
        step("t5_neg", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFE_0000);
        ir_load = 1'b1; ir_in = 32'h0001_FFFF;
        step("t5_pos", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0001_FFFF);
        seq_start = 1'b1; bus_ready = 1'b1;
        step("t5_rb0", 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0001_FFFF);
        bus_ready = 1'b1;
        step("t5_rc3", 16'h0000, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0001_FFFF);
        bus_ready = 1'b1;
`ifdef SEL_R0_WRITE_PROTECT_EN
        step("t5_ra0", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0001_FFFF);
`else
        step("t5_ra0", 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0001_FFFF);
`endif
        bus_ready = 1'b1;
        step("t5_done", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0001_FFFF);
        step("t5_idle", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0001_FFFF);

        // 6: multiple strobes -> grc wins with error; async reset in RC_OUT
        ir_load = 1'b1; ir_in = IR_A;
        step("t6_load", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, CX_A);
        gra = 1'b1; grc = 1'b1; rout = 1'b1;
        step("t6_multi", 16'h0000, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b0, CX_A);
        step("t6_err_pulse", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, CX_A);
        seq_start = 1'b1; bus_ready = 1'b1;
        step("t6_rb", 16'h0000, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b0, CX_A);
        bus_ready = 1'b1;
        step("t6_rc", 16'h0000, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b0, CX_A);
        @(posedge clk);
        #2;
        clr_n = 1'b0;
        push_exp(cyc, "t6_async_rst", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
        @(negedge clk);
        clr_n = 1'b1;
        step("t6_after_rst", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_select_sequencer.md
Name: reg_select_sequencer

Overview:
Parametrised, clocked successor to the CPU's register select/encode logic. It latches the instruction register (IR) and decodes its Ra/Rb/Rc fields into one-hot register-file in/out enables. Enables are driven either by manual control-unit strobes or by a built-in three-phase operand sequencer (Rb out, Rc out, Ra in) with bus handshake. It also produces the sign-extended C immediate. It sits between the control unit and the register file/bus.

Parameters:
NUM_REGS, 16, number of general registers; one-hot vector width
FIELD_W, 4, register field width; must be at least clog2(NUM_REGS)
IR_W, 32, instruction register width
RA_LSB, 23, LSB of the Ra field in IR
RB_LSB, 19, LSB of the Rb field in IR
RC_LSB, 15, LSB of the Rc field in IR
IMM_W, 18, C immediate width, taken from IR[IMM_W-1:0]
DATA_W, 32, sign-extended immediate width

Ports:
clk  in  1  system clock, rising edge
clr_n  in  1  asynchronous active-low reset
ir_load  in  1  capture ir_in into the internal IR on the next edge
ir_in  in  IR_W  instruction word from the bus
gra, grb, grc  in  1 each  manual field-select strobes
rin, rout, ba_out  in  1 each  manual in-enable, out-enable, base-address-out
seq_start  in  1  start the operand sequence
bus_ready  in  1  bus accepts the current phase
seq_busy  out  1  sequencer not in IDLE
seq_done  out  1  one-cycle completion pulse
reg_in  out  NUM_REGS  one-hot register load enables
reg_out  out  NUM_REGS  one-hot register drive enables
r0_zero_out  out  1  drive constant zero on the bus (ba_out with R0 selected)
c_sign_ext  out  DATA_W  sign-extended immediate
sel_err  out  1  one-cycle error pulse

Behaviour:
- Clock and reset: one clock (clk). Reset clr_n is asynchronous, active-low.
- Reset values: IR = 0, FSM = IDLE, and all outputs 0.
- Reset mid-sequence: outputs clear immediately (asynchronously), not at the next edge.
- IR capture:
  - ir_load captures ir_in at the edge while the FSM is IDLE.
  - ir_load while seq_busy=1: ignored, and sel_err pulses for one cycle.
- c_sign_ext: combinational from the IR register. Value is {(DATA_W-IMM_W){IR[IMM_W-1]}, IR[IMM_W-1:0]}.
- Manual mode (FSM IDLE only):
  - Strobes sampled at edge t drive registered outputs for exactly cycle t+1; 1-cycle latency, no hold.
  - Select priority is grc > grb > gra.
  - If more than one strobe is high, the highest-priority strobe wins and sel_err pulses.
  - If no strobe is high, reg_in and reg_out are 0.
  - reg_in[sel] = rin; reg_out[sel] = rout | ba_out.
  - Exception: when ba_out=1, rout=0 and sel=0, reg_out[0]=0 and r0_zero_out=1 instead.
  - Out-of-range field (value >= NUM_REGS): no enable asserted, and sel_err pulses.
- Sequencer FSM states: IDLE, RB_OUT, RC_OUT, RA_IN, DONE.
  - IDLE to RB_OUT when seq_start=1. If seq_start and manual strobes arrive together, the sequencer wins, manual strobes are ignored, and no error is raised.
  - RB_OUT to RC_OUT, RC_OUT to RA_IN, and RA_IN to DONE each advance on an edge with bus_ready=1. Otherwise the FSM stays put and its enable stays asserted.
  - DONE to IDLE unconditionally; seq_done=1 during DONE.
  - Per-state outputs: RB_OUT asserts reg_out[Rb]; RC_OUT asserts reg_out[Rc]; RA_IN asserts reg_in[Ra]. Each is a single one-hot bit.
  - seq_busy=1 in every state except IDLE.
  - seq_start outside IDLE is ignored.
  - Manual strobes are ignored while seq_busy=1.
  - Minimum sequence length is 5 cycles from seq_start (including DONE).
- Invariant: reg_in and reg_out are each at most one-hot at all times.

Optional Feature:
- Macro: SEL_R0_WRITE_PROTECT_EN.
- When defined:
  - reg_in[0] is never asserted.
  - Any attempted write to R0 (manual rin with sel=0, or RA_IN with Ra=0) pulses sel_err.
  - The sequencer still advances normally through RA_IN.
- When undefined: R0 is writable like any other register.

Decomposition:
- Shared package reg_sel_pkg:
  - FSM state enum (IDLE, RB_OUT, RC_OUT, RA_IN, DONE)
  - Default field LSB constants
  - Default NUM_REGS and IMM_W
- One sub-module, onehot_field_decoder: field value plus enable to a NUM_REGS one-hot vector, with an out-of-range flag. Instantiate it twice: once for the in path and once for the out path.

Test Plan:
1. Load IR=0x029B8000 (Ra=5, Rb=3, Rc=7); pulse gra+rin -> next cycle reg_in=0x0020 for exactly one cycle, reg_out=0, sel_err=0.
2. Same IR; seq_start with bus_ready=1 -> reg_out=0x0008, then reg_out=0x0080, then reg_in=0x0020, then seq_done=1, then seq_busy=0; 5 cycles total.
3. Same IR; bus_ready=0 for 2 cycles during RC_OUT -> reg_out=0x0080 held for 3 cycles, then the sequence completes normally.
4. IR with Rb=0: grb+ba_out -> reg_out=0, r0_zero_out=1. Then grb+rout -> reg_out=0x0001, r0_zero_out=0.
5. IR[17:0]=0x20000 -> c_sign_ext=0xFFFE0000. IR[17:0]=0x1FFFF -> c_sign_ext=0x0001FFFF.
6. gra+grc together -> grc selected, sel_err pulse. clr_n low during RC_OUT -> all outputs 0 immediately, FSM IDLE. With SEL_R0_WRITE_PROTECT_EN, RA_IN with Ra=0 -> reg_in stays 0 and sel_err pulses.
